mandelbrot_result_sink: RTL and testbench



---
 rtl/mandelbrot_pkg.sv | 22 ++
 rtl/mandelbrot_fb_ram.sv | 28 ++
 rtl/mandelbrot_result_sink.sv | 161 ++++++++++++++++
 tb/tb_mandelbrot_result_sink.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mandelbrot_pkg.sv
// Shared widths, state encoding and the count clip helper for the
// Mandelbrot result sink.
package mandelbrot_pkg;

    localparam int unsigned COORD_W = 11;
    localparam int unsigned ITER_W  = 16;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_RUN   = 2'd1,
        ST_DONE  = 2'd2
    } sink_state_t;

    // Saturate an iteration count to the largest value a dw-bit pixel holds.
    function automatic logic [ITER_W-1:0] clip_count(input logic [ITER_W-1:0] count,
                                                     input int unsigned       dw);
        logic [ITER_W-1:0] max_val;
        max_val = ITER_W'((32'd1 << dw) - 32'd1);
        return (count > max_val) ? max_val : count;
    endfunction

endpackage

// File: rtl/mandelbrot_fb_ram.sv
// Simple dual-port frame buffer: one write port, one registered read port,
// read-first on a same-address collision. No reset on the array or output.
module mandelbrot_fb_ram #(
    parameter int unsigned AW = 19,
    parameter int unsigned DW = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [0:(2**AW)-1];

    // Read samples the array before the write lands, giving old data on collision.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

endmodule

// File: rtl/mandelbrot_result_sink.sv
// Consumes the out-of-order Mandelbrot result stream, clips counts to palette
// indices, stores them in a raster-addressed frame buffer and exposes a
// registered scanout read port plus frame status.
module mandelbrot_result_sink
    import mandelbrot_pkg::*;
#(
    parameter int unsigned RESX = 640,
    parameter int unsigned RESY = 480,
    parameter int unsigned DW   = 4,
    parameter int unsigned AW   = 19
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               in_valid,
    input  logic [COORD_W-1:0] in_x,
    input  logic [COORD_W-1:0] in_y,
    input  logic [ITER_W-1:0]  in_i,
    input  logic               rd_req,
    input  logic [COORD_W-1:0] rd_x,
    input  logic [COORD_W-1:0] rd_y,
    output logic               rd_valid,
    output logic [DW-1:0]      rd_data,
    output logic               busy,
    output logic               frame_done,
    output logic [AW-1:0]      pixel_count,
    output logic               err_range,
    output logic               err_drop
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(RESX * RESY - 1);

    sink_state_t   state, state_next;
    logic [AW-1:0] clr_addr;

    // Stage 1 of the write pipe
    logic          s1_valid;
    logic          s1_inrange;
    logic [AW-1:0] s1_addr;
    logic [DW-1:0] s1_pix;

    logic          count_inc;
    logic          ram_we;
    logic [AW-1:0] ram_waddr;
    logic [DW-1:0] ram_wdata;

    logic          rd_inrange;
    logic          rd_zero;
    logic [DW-1:0] ram_q;

    assign count_inc  = (state == ST_RUN) && s1_valid && s1_inrange;
    assign busy       = (state == ST_CLEAR);
    assign frame_done = (state == ST_DONE);
    assign rd_inrange = (32'(rd_x) < RESX) && (32'(rd_y) < RESY);
    assign rd_data    = rd_zero ? '0 : ram_q;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_CLEAR;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and RAM write-port steering.
    always_comb begin
        state_next = state;
        ram_we     = 1'b0;
        ram_waddr  = s1_addr;
        ram_wdata  = s1_pix;
        if (start) begin
            state_next = ST_CLEAR;
        end else begin
            case (state)
                ST_CLEAR: if (clr_addr == LAST_ADDR) state_next = ST_RUN;
                ST_RUN:   if (count_inc && (pixel_count == LAST_ADDR)) state_next = ST_DONE;
                ST_DONE:  state_next = ST_DONE;
                default:  state_next = ST_CLEAR;
            endcase
        end
        if (state == ST_CLEAR) begin
            ram_we    = 1'b1;
            ram_waddr = clr_addr;
            ram_wdata = '0;
        end else begin
            ram_we    = s1_valid && s1_inrange;
        end
    end

    // Stage 1: register the result with its range flag, linear address and clipped pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1_inrange <= 1'b0;
            s1_addr    <= '0;
            s1_pix     <= '0;
        end else begin
            s1_valid   <= in_valid && !start;
            s1_inrange <= (32'(in_x) < RESX) && (32'(in_y) < RESY);
            s1_addr    <= AW'(32'(in_y) * RESX + 32'(in_x));
            s1_pix     <= DW'(clip_count(in_i, DW));
        end
    end

    // Clear address, pixel counter and sticky error flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clr_addr    <= '0;
            pixel_count <= '0;
            err_range   <= 1'b0;
            err_drop    <= 1'b0;
        end else if (start) begin
            clr_addr    <= '0;
            pixel_count <= '0;
            err_range   <= 1'b0;
            err_drop    <= 1'b0;
        end else begin
            if (state == ST_CLEAR) begin
                clr_addr <= (clr_addr == LAST_ADDR) ? '0 : clr_addr + AW'(1);
            end
            if (count_inc) begin
                pixel_count <= pixel_count + AW'(1);
            end
            if (s1_valid && (state == ST_CLEAR)) begin
                err_drop <= 1'b1;
            end
            if (s1_valid && !s1_inrange && (state != ST_CLEAR)) begin
                err_range <= 1'b1;
            end
        end
    end

    // Read side: valid follows the request by one cycle; out-of-range reads
    // (and the reset state) force the data output to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid <= 1'b0;
            rd_zero  <= 1'b1;
        end else begin
            rd_valid <= rd_req;
            if (rd_req) begin
                rd_zero <= !rd_inrange;
            end
        end
    end

    mandelbrot_fb_ram #(
        .AW (AW),
        .DW (DW)
    ) u_fb_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .re    (rd_req && rd_inrange),
        .raddr (AW'(32'(rd_y) * RESX + 32'(rd_x))),
        .rdata (ram_q)
    );

endmodule

// File: tb/tb_mandelbrot_result_sink.sv
// Directed self-checking bench for mandelbrot_result_sink (4x3 frame, 4-bit pixels).
module tb_mandelbrot_result_sink;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic [10:0] in_x, in_y;
    logic [15:0] in_i;
    logic        rd_req;
    logic [10:0] rd_x, rd_y;
    logic        rd_valid;
    logic [3:0]  rd_data;
    logic        busy;
    logic        frame_done;
    logic [3:0]  pixel_count;
    logic        err_range;
    logic        err_drop;

    int checks = 0;
    int errors = 0;

    mandelbrot_result_sink #(
        .RESX (4),
        .RESY (3),
        .DW   (4),
        .AW   (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .in_valid    (in_valid),
        .in_x        (in_x),
        .in_y        (in_y),
        .in_i        (in_i),
        .rd_req      (rd_req),
        .rd_x        (rd_x),
        .rd_y        (rd_y),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .busy        (busy),
        .frame_done  (frame_done),
        .pixel_count (pixel_count),
        .err_range   (err_range),
        .err_drop    (err_drop)
    );

    always #5 clk = ~clk;

    // Stimulus helpers (called at a negedge, return at a negedge).
    task automatic write_one(input int x, input int y, input int i);
        in_valid = 1'b1;
        in_x = 11'(x);
        in_y = 11'(y);
        in_i = 16'(i);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic do_read(input int x, input int y);
        rd_req = 1'b1;
        rd_x = 11'(x);
        rd_y = 11'(y);
        @(negedge clk);
        rd_req = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_clear(output int cycles);
        cycles = 0;
        while (busy && cycles < 200) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic test_reset();
        int cyc;
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_x = '0; in_y = '0; in_i = '0;
        rd_req = 1'b0; rd_x = '0; rd_y = '0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy got %0b exp 1", busy); end
        checks++; if (pixel_count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", pixel_count); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b exp 0", frame_done); end
        checks++; if ({err_range, err_drop} !== 2'b00) begin errors++; $display("FAIL reset_err got %b exp 00", {err_range, err_drop}); end
        checks++; if ({rd_valid, rd_data} !== 5'd0) begin errors++; $display("FAIL reset_rd got %0b/%0d exp 0/0", rd_valid, rd_data); end
        rst = 1'b0;
        wait_clear(cyc);
        checks++; if (cyc !== 12) begin errors++; $display("FAIL reset_clear_cycles got %0d exp 12", cyc); end
        checks++; if (pixel_count !== 4'd0) begin errors++; $display("FAIL post_clear_count got %0d exp 0", pixel_count); end
        do_read(3, 2);
        checks++; if ({rd_valid, rd_data} !== {1'b1, 4'd0}) begin errors++; $display("FAIL read_32 got %0b/%0d exp 1/0", rd_valid, rd_data); end
        @(negedge clk);
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL rd_valid_drop got %0b exp 0", rd_valid); end
    endtask

    task automatic test_single_write();
        write_one(1, 2, 7);
        @(negedge clk);
        checks++; if (pixel_count !== 4'd1) begin errors++; $display("FAIL single_count got %0d exp 1", pixel_count); end
        do_read(1, 2);
        checks++; if (rd_data !== 4'd7) begin errors++; $display("FAIL single_data got %0d exp 7", rd_data); end
    endtask

    task automatic test_read_first();
        write_one(2, 1, 9);
        do_read(2, 1);
        checks++; if (rd_data !== 4'd0) begin errors++; $display("FAIL collide_old got %0d exp 0", rd_data); end
        do_read(2, 1);
        checks++; if (rd_data !== 4'd9) begin errors++; $display("FAIL collide_new got %0d exp 9", rd_data); end
        checks++; if (pixel_count !== 4'd2) begin errors++; $display("FAIL collide_count got %0d exp 2", pixel_count); end
    endtask

    task automatic test_saturation();
        int cyc;
        do_start();
        wait_clear(cyc);
        checks++; if (cyc !== 12) begin errors++; $display("FAIL sat_clear_cycles got %0d exp 12", cyc); end
        write_one(0, 0, 15);
        @(negedge clk);
        do_read(0, 0);
        checks++; if (rd_data !== 4'd15) begin errors++; $display("FAIL sat_15 got %0d exp 15", rd_data); end
        write_one(0, 0, 300);
        @(negedge clk);
        do_read(0, 0);
        checks++; if (rd_data !== 4'd15) begin errors++; $display("FAIL sat_300 got %0d exp 15", rd_data); end
        checks++; if (pixel_count !== 4'd2) begin errors++; $display("FAIL sat_count got %0d exp 2", pixel_count); end
    endtask

    task automatic test_back_to_back();
        int cyc;
        int order [12] = '{5, 11, 0, 7, 2, 9, 4, 1, 10, 6, 3, 8};
        int ival  [12] = '{20, 1, 2, 3000, 4, 5, 6, 7, 8, 9, 15, 65535};
        int exp_v;
        do_start();
        wait_clear(cyc);
        for (int k = 0; k < 12; k++) begin
            in_valid = 1'b1;
            in_x = 11'(order[k] % 4);
            in_y = 11'(order[k] / 4);
            in_i = 16'(ival[order[k]]);
            @(negedge clk);
        end
        in_valid = 1'b0;
        checks++; if ({frame_done, pixel_count} !== {1'b0, 4'd11}) begin errors++; $display("FAIL frame_one_early got %0b/%0d exp 0/11", frame_done, pixel_count); end
        @(negedge clk);
        checks++; if ({frame_done, pixel_count} !== {1'b1, 4'd12}) begin errors++; $display("FAIL frame_done got %0b/%0d exp 1/12", frame_done, pixel_count); end
        for (int a = 0; a < 12; a++) begin
            exp_v = (ival[a] > 15) ? 15 : ival[a];
            do_read(a % 4, a / 4);
            checks++; if (rd_data !== 4'(exp_v)) begin errors++; $display("FAIL frame_pix addr %0d got %0d exp %0d", a, rd_data, exp_v); end
        end
        write_one(0, 0, 3);
        @(negedge clk);
        checks++; if ({frame_done, pixel_count} !== {1'b1, 4'd12}) begin errors++; $display("FAIL done_hold got %0b/%0d exp 1/12", frame_done, pixel_count); end
        do_read(0, 0);
        checks++; if (rd_data !== 4'd3) begin errors++; $display("FAIL done_overwrite got %0d exp 3", rd_data); end
    endtask

    task automatic test_range();
        int cyc;
        do_start();
        wait_clear(cyc);
        write_one(1, 1, 5);
        write_one(4, 0, 9);
        write_one(0, 3, 9);
        @(negedge clk);
        @(negedge clk);
        checks++; if ({err_range, err_drop} !== 2'b10) begin errors++; $display("FAIL range_err got %b exp 10", {err_range, err_drop}); end
        checks++; if (pixel_count !== 4'd1) begin errors++; $display("FAIL range_count got %0d exp 1", pixel_count); end
        do_read(0, 1);
        checks++; if (rd_data !== 4'd0) begin errors++; $display("FAIL range_alias got %0d exp 0", rd_data); end
        do_read(1, 1);
        checks++; if (rd_data !== 4'd5) begin errors++; $display("FAIL range_inpix got %0d exp 5", rd_data); end
        @(negedge clk);
        checks++; if ({rd_valid, rd_data} !== {1'b0, 4'd5}) begin errors++; $display("FAIL rd_hold got %0b/%0d exp 0/5", rd_valid, rd_data); end
        do_read(4, 0);
        checks++; if ({rd_valid, rd_data} !== {1'b1, 4'd0}) begin errors++; $display("FAIL rd_oor got %0b/%0d exp 1/0", rd_valid, rd_data); end
        do_start();
        checks++; if ({err_range, busy} !== 2'b01) begin errors++; $display("FAIL range_start_clear got %b exp 01", {err_range, busy}); end
        wait_clear(cyc);
    endtask

    task automatic test_drop();
        int cyc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        write_one(1, 1, 6);
        @(negedge clk);
        checks++; if ({err_drop, err_range} !== 2'b10) begin errors++; $display("FAIL drop_err got %b exp 10", {err_drop, err_range}); end
        wait_clear(cyc);
        checks++; if (cyc + 2 !== 12) begin errors++; $display("FAIL drop_clear_cycles got %0d exp 12", cyc + 2); end
        checks++; if (pixel_count !== 4'd0) begin errors++; $display("FAIL drop_count got %0d exp 0", pixel_count); end
        for (int a = 0; a < 12; a++) begin
            do_read(a % 4, a / 4);
            checks++; if (rd_data !== 4'd0) begin errors++; $display("FAIL drop_zero addr %0d got %0d exp 0", a, rd_data); end
        end
        checks++; if (err_drop !== 1'b1) begin errors++; $display("FAIL drop_sticky got %0b exp 1", err_drop); end
    endtask

    task automatic test_reset_mid();
        int cyc;
        write_one(2, 2, 4);
        @(negedge clk);
        checks++; if (pixel_count !== 4'd1) begin errors++; $display("FAIL mid_pre_count got %0d exp 1", pixel_count); end
        rst = 1'b1;
        #1;
        checks++; if ({busy, pixel_count, err_drop} !== {1'b1, 4'd0, 1'b0}) begin errors++; $display("FAIL mid_reset got %b exp 100000", {busy, pixel_count, err_drop}); end
        @(negedge clk);
        rst = 1'b0;
        wait_clear(cyc);
        checks++; if (cyc !== 12) begin errors++; $display("FAIL mid_clear_cycles got %0d exp 12", cyc); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_read_first();
        test_saturation();
        test_back_to_back();
        test_range();
        test_drop();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
